// File: rtl/patch_mon_pkg.sv
// Shared types and constants for the patch target monitor.
package patch_mon_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam int PIPE_LAT = 2;

    // LSB position of channel c in a flat CHANNELS*WIDTH vector.
    function automatic int chan_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/patch_target_monitor_if.sv
// Sample stream from the vector source into the monitor.
interface patch_target_monitor_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] golden;
    logic [CHANNELS*WIDTH-1:0] revised;
    logic [CHANNELS*WIDTH-1:0] care;

    modport master (output in_valid, golden, revised, care, input in_ready);
    modport slave  (input in_valid, golden, revised, care, output in_ready);
endinterface

// File: rtl/patch_chan_cmp.sv
// One channel's masked equality / complement check; purely combinational.
module patch_chan_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] revised,
    input  logic [WIDTH-1:0] care,
    input  logic             mode,
    output logic             fail
);
    assign fail = |((revised ^ (golden ^ {WIDTH{mode}})) & care);
endmodule

// File: rtl/patch_target_monitor.sv
// Windowed golden/revised comparator: per-sample target bit plus sticky
// failure, saturating mismatch count and first-failing-sample index.
module patch_target_monitor
    import patch_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    win_len,
    input  logic [CHANNELS-1:0] mode,
    patch_target_monitor_if.slave smp,
    output logic                t_out,
    output logic                t_valid,
    output logic [CHANNELS-1:0] ch_fail,
    output logic [CNT_W-1:0]    mis_cnt,
    output logic [CNT_W-1:0]    first_fail,
    output logic                any_fail,
    output logic                busy,
    output logic                done
);
    typedef struct packed {
        logic [CHANNELS-1:0] fail;
        logic [CNT_W-1:0]    idx;
    } s1_t;

    state_t              state;
    logic [CNT_W-1:0]    win_len_q;
    logic [CNT_W-1:0]    idx;
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] fail_c;
    s1_t                 s1_q;
    logic [PIPE_LAT:1]   vld_pipe;
    logic                acc, last, arm;

    assign smp.in_ready = (state == ST_RUN);
    assign acc          = smp.in_valid && smp.in_ready;
    assign last         = acc && (idx == win_len_q - CNT_W'(1));
    assign arm          = start && (state == ST_IDLE || state == ST_DONE);
    assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
    assign done         = (state == ST_DONE);
    assign t_valid      = vld_pipe[PIPE_LAT];
    assign any_fail     = |ch_fail;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        patch_chan_cmp #(.WIDTH(WIDTH)) u_cmp (
            .golden (smp.golden [chan_lsb(c, WIDTH) +: WIDTH]),
            .revised(smp.revised[chan_lsb(c, WIDTH) +: WIDTH]),
            .care   (smp.care   [chan_lsb(c, WIDTH) +: WIDTH]),
            .mode   (mode_q[c]),
            .fail   (fail_c[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            win_len_q <= '0;
            mode_q    <= '0;
            idx       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        win_len_q <= win_len;
                        mode_q    <= mode;
                        idx       <= '0;
                        state     <= (win_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (acc) begin
                        idx <= idx + CNT_W'(1);
                        if (last) state <= ST_DRAIN;
                    end
                end
                // Leave once the last sample has left stage 1; its result is
                // on t_valid during the final DRAIN cycle.
                ST_DRAIN: if (!(|vld_pipe[PIPE_LAT-1:1])) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            s1_q       <= '0;
            t_out      <= 1'b0;
            ch_fail    <= '0;
            mis_cnt    <= '0;
            first_fail <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIPE_LAT-1:1], acc};
            if (acc) begin
                s1_q.fail <= fail_c;
                s1_q.idx  <= idx;
            end
            t_out <= vld_pipe[1] && !(|s1_q.fail);
            // Pipeline is empty whenever a start is accepted, so clearing
            // never races with a result.
            if (arm) begin
                ch_fail    <= '0;
                mis_cnt    <= '0;
                first_fail <= '0;
            end else if (vld_pipe[1] && (|s1_q.fail)) begin
                ch_fail <= ch_fail | s1_q.fail;
                if (!(&mis_cnt)) mis_cnt <= mis_cnt + CNT_W'(1);
                if (!any_fail) first_fail <= s1_q.idx;
            end
        end
    end

endmodule

// File: tb/tb_patch_target_monitor.sv
// Directed bench: main instance (CNT_W=16) plus a CNT_W=4 instance for saturation.
module tb_patch_target_monitor;
    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    patch_target_monitor_if #(.WIDTH(W), .CHANNELS(CH)) smp ();
    patch_target_monitor_if #(.WIDTH(W), .CHANNELS(CH)) smp_s ();

    logic           start, start_s;
    logic [CW-1:0]  win_len;
    logic [CWS-1:0] win_len_s;
    logic [CH-1:0]  mode, mode_s;

    logic           t_out, t_valid, any_fail, busy, done;
    logic [CH-1:0]  ch_fail;
    logic [CW-1:0]  mis_cnt, first_fail;
    logic           t_out_s, t_valid_s, any_fail_s, busy_s, done_s;
    logic [CH-1:0]  ch_fail_s;
    logic [CWS-1:0] mis_cnt_s, first_fail_s;

    patch_target_monitor #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .mode(mode),
        .smp(smp), .t_out(t_out), .t_valid(t_valid), .ch_fail(ch_fail),
        .mis_cnt(mis_cnt), .first_fail(first_fail), .any_fail(any_fail),
        .busy(busy), .done(done));

    patch_target_monitor #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .win_len(win_len_s), .mode(mode_s),
        .smp(smp_s), .t_out(t_out_s), .t_valid(t_valid_s), .ch_fail(ch_fail_s),
        .mis_cnt(mis_cnt_s), .first_fail(first_fail_s), .any_fail(any_fail_s),
        .busy(busy_s), .done(done_s));

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic tq[$];
    int   busy_cnt = 0;
    int   tv_s_cnt = 0;

    always @(negedge clk) begin
        if (t_valid) tq.push_back(t_out);
        if (busy) busy_cnt++;
        if (t_valid_s) tv_s_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0F17 ^ (32'h0101_0101 * 32'(i));
    endfunction

    function automatic logic [31:0] res_bits(input int base);
        logic [31:0] v = '0;
        for (int i = base; i < tq.size(); i++) v[i-base] = tq[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_win(input logic [CW-1:0] len, input logic [CH-1:0] md);
        @(posedge clk);
        #1;
        start   = 1'b1;
        win_len = len;
        mode    = md;
        cyc     = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] g, input logic [31:0] r, input logic [31:0] c);
        smp.in_valid = 1'b1;
        smp.golden   = g;
        smp.revised  = r;
        smp.care     = c;
        tick();
        smp.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                at = cyc;
                return;
            end
            tick();
        end
    endtask

    int base, at, bc;
    logic [31:0] r;

    initial begin
        rst = 1'b1;
        start = 1'b0; win_len = '0; mode = '0;
        start_s = 1'b0; win_len_s = '0; mode_s = '0;
        smp.in_valid = 1'b0; smp.golden = '0; smp.revised = '0; smp.care = '0;
        smp_s.in_valid = 1'b0; smp_s.golden = '0; smp_s.revised = '0; smp_s.care = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ready", 64'(smp.in_ready), 64'd0);
        chk("rst_tvalid", 64'(t_valid), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_acc", 64'({any_fail, ch_fail, mis_cnt, first_fail}), 64'd0);

        // Match window
        base = tq.size();
        start_win(5, 4'b0000);
        for (int i = 0; i < 5; i++) feed(pat(i), pat(i), 32'hFFFF_FFFF);
        wait_done(at);
        chk("match_done_cyc", 64'(at), 64'd8);
        chk("match_nres", 64'(tq.size() - base), 64'd5);
        chk("match_tout", 64'(res_bits(base)), 64'h1F);
        chk("match_mis", 64'(mis_cnt), 64'd0);
        chk("match_any", 64'({any_fail, ch_fail}), 64'd0);

        // Single fault: sample 3, channel 2 bit 5
        base = tq.size();
        start_win(5, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            r = pat(i);
            if (i == 3) r[21] = ~r[21];
            feed(pat(i), r, 32'hFFFF_FFFF);
        end
        wait_done(at);
        chk("fault_done_cyc", 64'(at), 64'd8);
        chk("fault_tout", 64'(res_bits(base)), 64'h17);
        chk("fault_chfail", 64'(ch_fail), 64'h4);
        chk("fault_mis", 64'(mis_cnt), 64'd1);
        chk("fault_first", 64'(first_fail), 64'd3);
        chk("fault_any", 64'(any_fail), 64'd1);

        // Zero window clears accumulators, never goes busy
        base = tq.size();
        bc   = busy_cnt;
        start_win(0, 4'b0000);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_clear", 64'({any_fail, ch_fail, mis_cnt, first_fail}), 64'd0);
        smp.in_valid = 1'b1; smp.golden = pat(1); smp.revised = ~pat(1); smp.care = '1;
        repeat (4) tick();
        chk("done_ready", 64'(smp.in_ready), 64'd0);
        smp.in_valid = 1'b0;
        chk("zero_busy", 64'(busy_cnt - bc), 64'd0);
        chk("zero_nres", 64'(tq.size() - base), 64'd0);
        chk("done_idle_mis", 64'(mis_cnt), 64'd0);
        chk("done_hold", 64'(done), 64'd1);

        // Mask/mode: ch0 complemented, ch3 uncared garbage
        base = tq.size();
        start_win(5, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            r = pat(i);
            r[7:0]   = ~r[7:0];
            r[31:24] = 8'($urandom);
            feed(pat(i), r, 32'h00FF_FFFF);
        end
        wait_done(at);
        chk("mask_done_cyc", 64'(at), 64'd8);
        chk("mask_tout", 64'(res_bits(base)), 64'h1F);
        chk("mask_chfail", 64'(ch_fail), 64'd0);

        // Saturation on the CNT_W=4 instance, with start pulsed mid-run
        @(posedge clk);
        #1;
        start_s = 1'b1; win_len_s = 4'd15; mode_s = '0;
        bc = tv_s_cnt;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 15; i++) begin
            smp_s.in_valid = 1'b1;
            smp_s.golden   = pat(i);
            smp_s.revised  = ~pat(i);
            smp_s.care     = '1;
            start_s        = (i == 4);
            win_len_s      = (i == 4) ? 4'd3 : 4'd15;
            tick();
        end
        smp_s.in_valid = 1'b0;
        start_s = 1'b0;
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            if (done_s) at = i;
            else tick();
        end
        chk("sat_done_seen", 64'(at >= 0), 64'd1);
        chk("sat_mis", 64'(mis_cnt_s), 64'hF);
        chk("sat_first", 64'(first_fail_s), 64'd0);
        chk("sat_nres", 64'(tv_s_cnt - bc), 64'd15);
        chk("sat_chfail", 64'(ch_fail_s), 64'hF);
        smp_s.in_valid = 1'b1;
        repeat (3) tick();
        smp_s.in_valid = 1'b0;
        chk("sat_idle_mis", 64'(mis_cnt_s), 64'hF);
        chk("sat_idle_nres", 64'(tv_s_cnt - bc), 64'd15);

        // Reset after 3 accepted failing samples
        start_win(10, 4'b0000);
        for (int i = 0; i < 3; i++) feed(pat(i), ~pat(i), 32'hFFFF_FFFF);
        rst = 1'b1;
        start = 1'b1;
        win_len = 16'd4;
        smp.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        smp.in_valid = 1'b0;
        chk("mrst_tv_tout", 64'({t_valid, t_out}), 64'd0);
        chk("mrst_busy_done", 64'({busy, done, smp.in_ready}), 64'd0);
        chk("mrst_acc", 64'({any_fail, ch_fail, mis_cnt, first_fail}), 64'd0);
        base = tq.size();
        repeat (4) tick();
        chk("mrst_late_tv", 64'(tq.size() - base), 64'd0);
        start_win(3, 4'b0000);
        for (int i = 0; i < 3; i++) feed(pat(i + 7), pat(i + 7), 32'hFFFF_FFFF);
        wait_done(at);
        chk("post_done_cyc", 64'(at), 64'd6);
        chk("post_tout", 64'(res_bits(base)), 64'h7);
        chk("post_mis", 64'(mis_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/patch_target_monitor.md
# patch_target_monitor

Sequential, parametrised successor to the combinational rectification target `t_0`. It streams golden/revised signal vectors over a programmable window of samples. For each sample it forms, per channel, a masked equality (or complement) check, then ANDs the channels into a registered target bit. It accumulates sticky per-channel failures, a saturating mismatch count and the index of the first failing sample. It sits between the simulation vector source and the ECO verification controller.

## Interface
- `WIDTH`, 8, bits per channel.
- `CHANNELS`, 4, number of compared channels (≥1).
- `CNT_W`, 16, width of the window length, sample index and mismatch counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; arms a new window (sampled in IDLE or DONE only).
- `win_len` in CNT_W: samples in the window, latched on accepted `start`.
- `mode` in CHANNELS: per channel, 0 = revised must equal golden, 1 = revised must equal ~golden; latched on `start`.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: sample accepted when `in_valid && in_ready`.
- `golden` in CHANNELS*WIDTH: reference vector, channel c at `[c*WIDTH +: WIDTH]`.
- `revised` in CHANNELS*WIDTH: patched-circuit vector.
- `care` in CHANNELS*WIDTH: 1 = bit is compared.
- `t_out` out 1: per-sample target, 1 = all channels match.
- `t_valid` out 1: qualifies `t_out`.
- `ch_fail` out CHANNELS: sticky per-channel failure for the current window.
- `mis_cnt` out CNT_W: count of failing samples, saturating at all-ones.
- `first_fail` out CNT_W: index of the first failing sample; valid when `any_fail`.
- `any_fail` out 1: OR of `ch_fail`.
- `busy` out 1: FSM in RUN or DRAIN.
- `done` out 1: high in DONE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE → RUN on `start` with `win_len` ≠ 0. This clears `ch_fail`, `mis_cnt`, `first_fail`, `any_fail` and the sample index, and latches `win_len` and `mode`.
  - IDLE/DONE → DONE on `start` with `win_len` = 0. Counters are cleared and no samples are taken.
  - RUN → DRAIN on acceptance of sample `win_len`-1.
  - DRAIN → DONE once the pipeline is empty (2 cycles).
  - `start` in RUN or DRAIN is ignored.
- `in_ready` = 1 only in RUN. `in_valid` outside RUN is dropped, and no output changes.
- Per-channel check: `fail_c = |((revised_c ^ (golden_c ^ {WIDTH{mode_c}})) & care_c)`. A channel with all-zero `care` never fails.
- `t_out = ~|fail`.
- On each result with `t_out` = 0:
  - `ch_fail |= fail`;
  - `mis_cnt` increments unless it is all-ones;
  - `first_fail` is written with that sample's index only if `any_fail` was 0.
- The sample index is a CNT_W counter of accepted samples. It travels down the pipeline with its sample.

## Timing
- Pipeline: stage 1 registers the per-channel `fail` vector plus the index. Stage 2 registers `t_out` and `t_valid` and updates the accumulators.
- Latency: a sample accepted at edge k gives `t_valid` = 1 in cycle k+2.
- Throughput: one sample per cycle; no back-pressure inside RUN.
- `done` rises the cycle after the last `t_valid`. Accumulators are final when `done` = 1.
- Reset values:
  - FSM goes to IDLE;
  - `in_ready`, `t_out`, `t_valid`, `busy`, `done`, `any_fail` = 0;
  - `ch_fail`, `mis_cnt`, `first_fail` = 0;
  - pipeline valid bits = 0.
- Reset mid-RUN discards in-flight samples. No `t_valid` appears after the reset cycle.
- `start` together with `rst`: reset wins.
- Window of 2^CNT_W−1 samples: the index never wraps inside one window.

## Structure
- Package `patch_mon_pkg`: FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DRAIN`, `ST_DONE`), the `PIPE_LAT` = 2 constant, and the channel-slice helper function.
- Sub-module `patch_chan_cmp`, instantiated per channel with a `WIDTH` parameter. It takes `golden`, `revised`, `care` and `mode` and drives the combinational `fail` output.
- The top holds the FSM, the stage registers and the accumulators.

## Test plan
- Match window: WIDTH=8, CHANNELS=4, `win_len`=5, revised = golden, `care`=all-ones. Expect 5 `t_valid` pulses with `t_out`=1, `mis_cnt`=0, `any_fail`=0, and `done` at cycle 2+5+1 after `start`.
- Single fault: sample 3 has channel 2 bit 5 flipped. Expect `t_out`=0 on the 4th result only, `ch_fail`=4'b0100, `mis_cnt`=1, `first_fail`=3.
- Mask/mode: `mode`=4'b0001, `revised[7:0]`=~`golden[7:0]`, channel 3 random with `care`=0. Expect all `t_out`=1.
- Zero window: `win_len`=0. Expect `done`=1 the next cycle, `busy` never high, no `t_valid`.
- Saturation/idle input: CNT_W=4, `win_len`=15, every sample failing. Expect `mis_cnt`=15 with no wrap. `in_valid` held in DONE and `start` pulsed in RUN cause no effect.
- Reset mid-run: assert `rst` after 3 accepted samples. Expect all outputs 0 the next cycle, no late `t_valid`, and a following `start` behaving normally.
